udp_send_top: RTL and testbench

//  UDP/IPv4/Ethernet frame builder. Captures one app payload (32-bit beats) in clk_32, prepends
//  14B Ethernet + 20B IPv4 + 8B UDP headers, streams the frame as bytes on an 8-bit AXIS in clk_8.

---
 rtl/udp_send_top.sv | 183 ++++++++++++++++++
 tb/tb_udp_send_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_send_top.sv
// udp_send_top: captures one app payload in clk_32, prepends Ethernet/IPv4/UDP headers
// and streams the frame as bytes on an 8-bit AXI-Stream in clk_8.
module udp_send_top #(
    parameter logic [15:0] SRC_PORT  = 16'h1234,
    parameter logic [7:0]  IP_TTL    = 8'h40,
    parameter int          BUF_WORDS = 128
) (
    input  logic        clk_32,
    input  logic        reset_32,
    input  logic        clk_8,
    input  logic        reset_8,
    input  logic [31:0] local_IP_in,
    input  logic [47:0] local_MAC_in,
    input  logic [31:0] remote_ip_addr_in,
    input  logic [47:0] remote_mac_addr_in,
    input  logic        arp_reply_in,
    output logic        arp_reply_ack_out,
    input  logic        udp_from_app_valid,
    input  logic [31:0] udp_from_app_data,
    input  logic [3:0]  udp_from_app_keep,
    input  logic        udp_from_app_last,
    output logic        udp_to_app_ready,
    input  logic [31:0] dest_ip_addr,
    input  logic [15:0] dest_port,
    input  logic [15:0] data_from_app_length,
    input  logic [7:0]  tcp_ctrl_type,
    output logic [7:0]  axis_tdata_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in
);
    localparam int AW = $clog2(BUF_WORDS);

    typedef enum logic [1:0] {CAPTURE, HDR, WAIT_TX} state_t;
    state_t state_q, state_d;

    logic        ready_q, ack_q, arp_valid_q, req_q, done_q;
    logic [31:0] arp_ip_q, dip_q, lip_q;
    logic [47:0] arp_mac_q, dmac_q, lmac_q;
    logic [AW:0] wr_ptr_q;
    logic [15:0] id_q, dport_q, dlen_q, len_q;
    logic [335:0] hdr_q;
    logic [2:0]  done_s_q, req_s_q;
    logic [31:0] mem [BUF_WORDS];

    logic        acc, fin, done_seen, arp_take;
    logic [15:0] cap_len, l_w, tot_w, udp_w, fold2;
    logic [31:0] sum_w;
    logic [16:0] fold1;

    always_comb begin
        acc       = (state_q == CAPTURE) && ready_q && udp_from_app_valid;
        fin       = acc && (udp_from_app_last || wr_ptr_q == (AW+1)'(BUF_WORDS - 1));
        done_seen = done_s_q[2] ^ done_s_q[1];
        arp_take  = arp_reply_in && !ack_q;
        state_d   = state_q;
        state_d   = (state_q == CAPTURE && fin)       ? HDR     :
                    (state_q == HDR)                  ? WAIT_TX :
                    (state_q == WAIT_TX && done_seen) ? CAPTURE : state_q;
        cap_len   = 16'({wr_ptr_q, 2'b00});
        l_w       = (dlen_q < cap_len) ? dlen_q : cap_len;
        tot_w     = 16'd28 + l_w;
        udp_w     = 16'd8 + l_w;
        sum_w     = 32'h4500 + 32'(tot_w) + 32'(id_q) + 32'h4000 + 32'({IP_TTL, 8'h11})
                  + 32'(lip_q[31:16]) + 32'(lip_q[15:0]) + 32'(dip_q[31:16]) + 32'(dip_q[15:0]);
        fold1     = 17'(sum_w[15:0]) + 17'(sum_w[31:16]);
        fold2     = fold1[15:0] + 16'(fold1[16]);
    end

    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) state_q <= CAPTURE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            arp_valid_q <= 1'b0;
            arp_ip_q    <= '0;
            arp_mac_q   <= '0;
            wr_ptr_q    <= '0;
            id_q        <= '0;
            dip_q       <= '0;
            dport_q     <= '0;
            dlen_q      <= '0;
            lip_q       <= '0;
            lmac_q      <= '0;
            dmac_q      <= '0;
            len_q       <= '0;
            hdr_q       <= '0;
            req_q       <= 1'b0;
            done_s_q    <= '0;
        end else begin
            ready_q  <= state_d == CAPTURE;
            ack_q    <= arp_take;
            done_s_q <= {done_s_q[1:0], done_q};
            if (arp_take) begin
                arp_valid_q <= 1'b1;
                arp_ip_q    <= remote_ip_addr_in;
                arp_mac_q   <= remote_mac_addr_in;
            end
            if (acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fin) begin
                dip_q   <= dest_ip_addr;
                dport_q <= dest_port;
                dlen_q  <= data_from_app_length;
                lip_q   <= local_IP_in;
                lmac_q  <= local_MAC_in;
                dmac_q  <= (arp_valid_q && arp_ip_q == dest_ip_addr) ? arp_mac_q : '1;
            end
            // Header and length stay frozen until the serializer reports done.
            if (state_q == HDR) begin
                len_q <= l_w;
                hdr_q <= {dmac_q, lmac_q, 16'h0800, 16'h4500, tot_w, id_q, 16'h4000, IP_TTL,
                          8'h11, ~fold2, lip_q, dip_q, SRC_PORT, dport_q, udp_w, 16'h0000};
                req_q <= ~req_q;
            end
            if (state_q == WAIT_TX && done_seen) begin
                id_q     <= id_q + 16'd1;
                wr_ptr_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_32) begin
        if (acc) mem[wr_ptr_q[AW-1:0]] <= udp_from_app_data;
    end

    logic          tvalid_q, tlast_q, start, hs;
    logic [7:0]    tdata_q, byte_w;
    logic [9:0]    cnt_q, nxt, last_idx;
    logic [5:0]    hi;
    logic [AW+1:0] p;
    logic [31:0]   rd_w;

    always_comb begin
        start    = !tvalid_q && (req_s_q[2] ^ req_s_q[1]);
        hs       = tvalid_q && axis_tready_in;
        nxt      = start ? 10'd0 : cnt_q + 10'd1;
        hi       = 6'd41 - nxt[5:0];
        p        = (AW+2)'(nxt - 10'd42);
        rd_w     = mem[p[AW+1:2]];
        byte_w   = (nxt < 10'd42) ? hdr_q[{hi, 3'b000} +: 8] : rd_w[{~p[1:0], 3'b000} +: 8];
        last_idx = 10'd41 + len_q[9:0];
    end

    always_ff @(posedge clk_8 or posedge reset_8) begin
        if (reset_8) begin
            req_s_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            req_s_q <= {req_s_q[1:0], req_q};
            if (start) begin
                tvalid_q <= 1'b1;
                cnt_q    <= '0;
                tdata_q  <= byte_w;
                tlast_q  <= 1'b0;
            end else if (hs && tlast_q) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tdata_q  <= '0;
                done_q   <= ~done_q;
            end else if (hs) begin
                cnt_q   <= nxt;
                tdata_q <= byte_w;
                tlast_q <= nxt == last_idx;
            end
        end
    end

    logic unused;
    assign unused            = ^{tcp_ctrl_type, udp_from_app_keep, len_q[15:10]};
    assign udp_to_app_ready  = ready_q;
    assign arp_reply_ack_out = ack_q;
    assign axis_tdata_out    = tdata_q;
    assign axis_tvalid_out   = tvalid_q;
    assign axis_tlast_out    = tlast_q;
endmodule

// File: tb/tb_udp_send_top.sv
// tb_udp_send_top: scoreboard bench for the UDP frame builder.
module tb_udp_send_top;
    localparam logic [31:0] LIP   = 32'hC0A80001;
    localparam logic [47:0] LMAC  = 48'h02AABBCCDDEE;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] RMAC  = 48'h001122334455;

    logic clk_32 = 0, clk_8 = 0, reset_32 = 1, reset_8 = 1;
    logic [31:0] remote_ip_addr_in = 0, dest_ip_addr = 0, udp_from_app_data = 0;
    logic [47:0] remote_mac_addr_in = 0;
    logic arp_reply_in = 0, udp_from_app_valid = 0, udp_from_app_last = 0, axis_tready_in = 1;
    logic [3:0] udp_from_app_keep = 4'hF;
    logic [15:0] dest_port = 0, data_from_app_length = 0;
    logic [7:0] tcp_ctrl_type = 0;
    logic arp_reply_ack_out, udp_to_app_ready, axis_tvalid_out, axis_tlast_out;
    logic [7:0] axis_tdata_out;

    udp_send_top dut (
        .clk_32(clk_32), .reset_32(reset_32), .clk_8(clk_8), .reset_8(reset_8),
        .local_IP_in(LIP), .local_MAC_in(LMAC),
        .remote_ip_addr_in(remote_ip_addr_in), .remote_mac_addr_in(remote_mac_addr_in),
        .arp_reply_in(arp_reply_in), .arp_reply_ack_out(arp_reply_ack_out),
        .udp_from_app_valid(udp_from_app_valid), .udp_from_app_data(udp_from_app_data),
        .udp_from_app_keep(udp_from_app_keep), .udp_from_app_last(udp_from_app_last),
        .udp_to_app_ready(udp_to_app_ready), .dest_ip_addr(dest_ip_addr), .dest_port(dest_port),
        .data_from_app_length(data_from_app_length), .tcp_ctrl_type(tcp_ctrl_type),
        .axis_tdata_out(axis_tdata_out), .axis_tvalid_out(axis_tvalid_out),
        .axis_tlast_out(axis_tlast_out), .axis_tready_in(axis_tready_in)
    );

    always #5 clk_32 = ~clk_32;
    always #7 clk_8 = ~clk_8;

    int checks = 0, errors = 0, rx_n = 0;
    logic [8:0] exp_q[$];
    logic [7:0] rx[600];
    logic [15:0] exp_id = 0;
    logic stall_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [47:0] dmac, input logic [31:0] dip,
                              input logic [15:0] dport, input int L);
        logic [335:0] hv;
        logic [7:0] h[42];
        logic [31:0] s;
        logic [15:0] c;
        hv = {dmac, LMAC, 16'h0800, 16'h4500, 16'(28 + L), exp_id, 16'h4000, 8'h40, 8'h11,
              16'h0000, LIP, dip, 16'h1234, dport, 16'(8 + L), 16'h0000};
        for (int i = 0; i < 42; i++) h[i] = hv[335 - 8*i -: 8];
        s = 0;
        for (int j = 0; j < 10; j++) s += {16'h0, h[14 + 2*j], h[15 + 2*j]};
        s = s[15:0] + s[31:16];
        s = s[15:0] + s[31:16];
        c = ~s[15:0];
        h[24] = c[15:8];
        h[25] = c[7:0];
        for (int i = 0; i < 42 + L; i++)
            exp_q.push_back({i == 41 + L, (i < 42) ? h[i] : 8'(i - 42)});
        exp_id++;
    endtask

    task automatic send(input int nb, input int len, input logic [31:0] dip,
                        input logic [15:0] dport, input bit with_last);
        int t;
        bit to = 0;
        dest_ip_addr = dip;
        dest_port = dport;
        data_from_app_length = 16'(len);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk_32);
            udp_from_app_valid = 1;
            udp_from_app_data = 32'h00010203 + 32'(b) * 32'h04040404;
            udp_from_app_last = with_last && (b == nb - 1);
            t = 0;
            while (!udp_to_app_ready && t < 2000) begin
                @(negedge clk_32);
                t++;
            end
            if (t >= 2000) to = 1;
            @(posedge clk_32);
        end
        @(negedge clk_32);
        udp_from_app_valid = 0;
        udp_from_app_last = 0;
        check("app_ready_timeout", to, 0);
    endtask

    task automatic wait_frame(input int flen);
        int t = 0;
        bit rdy = 0;
        logic [31:0] s = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk_8);
            rdy |= udp_to_app_ready;
            t++;
        end
        check("frame_timeout", t >= 20000, 0);
        check("ready_low_during_tx", rdy, 0);
        @(posedge clk_8);
        #1;
        check("tvalid_gap", axis_tvalid_out, 0);
        check("frame_len", rx_n, flen);
        for (int j = 0; j < 10; j++) s += {16'h0, rx[14 + 2*j], rx[15 + 2*j]};
        s = s[15:0] + s[31:16];
        s = s[15:0] + s[31:16];
        check("ip_csum_sum", s[15:0], 16'hFFFF);
        check("ip_id", {rx[18], rx[19]}, exp_id - 16'd1);
    endtask

    task automatic run(input int nb, input int len, input logic [31:0] dip,
                       input logic [15:0] dport, input logic [47:0] dmac, input int L);
        rx_n = 0;
        push_frame(dmac, dip, dport, L);
        send(nb, len, dip, dport, 1);
        wait_frame(42 + L);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", udp_to_app_ready, 0);
        check("rst_ack", arp_reply_ack_out, 0);
        check("rst_tdata", axis_tdata_out, 0);
        check("rst_tvalid", axis_tvalid_out, 0);
        check("rst_tlast", axis_tlast_out, 0);
    endtask

    initial begin
        axis_tready_in = 1;
        forever begin
            @(posedge clk_8);
            #1;
            axis_tready_in = stall_mode ? !axis_tready_in : 1'b1;
        end
    end

    initial begin
        logic [8:0] e;
        logic [9:0] held;
        bit held_v = 0;
        forever begin
            @(negedge clk_8);
            if (held_v) check("hold_while_stalled", {axis_tvalid_out, axis_tlast_out, axis_tdata_out}, held);
            held_v = axis_tvalid_out && !axis_tready_in;
            held = {1'b1, axis_tlast_out, axis_tdata_out};
            if (axis_tvalid_out && axis_tready_in) begin
                if (exp_q.size() == 0) check("unexpected_byte", axis_tvalid_out, 0);
                else begin
                    e = exp_q.pop_front();
                    check("tdata", axis_tdata_out, e[7:0]);
                    check("tlast", axis_tlast_out, e[8]);
                end
                if (rx_n < 600) rx[rx_n] = axis_tdata_out;
                rx_n++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk_32);
        reset_32 = 0;
        reset_8 = 0;

        run(27, 108, 32'hC0A80002, 16'h1F90, BCAST, 108);
        check("ethertype", {rx[12], rx[13]}, 16'h0800);
        check("ip_totlen", {rx[16], rx[17]}, 16'h0088);
        check("udp_len", {rx[38], rx[39]}, 16'h0074);
        check("last_payload", rx[149], 8'h6B);
        run(27, 108, 32'hC0A80002, 16'h1F90, BCAST, 108);

        @(negedge clk_32);
        remote_ip_addr_in = 32'hC0A80002;
        remote_mac_addr_in = RMAC;
        arp_reply_in = 1;
        @(negedge clk_32);
        check("arp_ack_high", arp_reply_ack_out, 1);
        arp_reply_in = 0;
        @(negedge clk_32);
        check("arp_ack_low", arp_reply_ack_out, 0);

        run(27, 108, 32'hC0A80002, 16'h1F90, RMAC, 108);
        run(27, 108, 32'hC0A80003, 16'h0050, BCAST, 108);

        stall_mode = 1;
        run(27, 108, 32'hC0A80002, 16'h1F90, RMAC, 108);
        stall_mode = 0;

        run(27, 200, 32'hC0A80002, 16'h1F90, RMAC, 108);
        run(2, 5, 32'hC0A80002, 16'h2000, RMAC, 5);
        run(1, 0, 32'hC0A80002, 16'h2001, RMAC, 0);

        send(10, 108, 32'hC0A80002, 16'h1F90, 0);
        @(negedge clk_32);
        reset_32 = 1;
        reset_8 = 1;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk_32);
        reset_32 = 0;
        reset_8 = 0;
        exp_id = 0;
        run(27, 108, 32'hC0A80002, 16'h1F90, BCAST, 108);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
